// File: rtl/operand_fetch.sv
// operand_fetch: register-read stage of the IITB-RISC pipeline.
// Decodes which sources an instruction reads, fetches them from the register
// file with PC / EX / WB bypassing, and stalls on RAW hazards that bypassing
// cannot resolve. The registered 41-bit bundle {opcode, dest, cz, opA, opB}
// feeds execute.
// Build option: define OPERAND_FORWARD_EN to enable forwarding from EX. When
// it is undefined, any EX writer of a used source stalls the stage instead.
`timescale 1ns/1ps

module operand_fetch #(
  parameter int DW       = 16,
  parameter int RW       = 3,
  parameter int STALL_CW = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      id_valid,
  input  logic [15:0]               id_instr,
  input  logic [DW-1:0]             id_pc,
  output logic                      id_ready,
  output logic [RW-1:0]             rf_addr_a,
  output logic [RW-1:0]             rf_addr_b,
  input  logic [DW-1:0]             rf_data_a,
  input  logic [DW-1:0]             rf_data_b,
  input  logic                      ex_wr_valid,
  input  logic [RW-1:0]             ex_wr_reg,
  input  logic [DW-1:0]             ex_wr_data,
  input  logic                      ex_is_load,
  input  logic                      wb_wr_valid,
  input  logic [RW-1:0]             wb_wr_reg,
  input  logic [DW-1:0]             wb_wr_data,
  input  logic                      flush,
  input  logic                      ex_ready,
  output logic                      rr_valid,
  output logic [4+RW+2+2*DW-1:0]    rr_bundle,
  output logic [STALL_CW-1:0]       stall_cnt
);

  localparam logic [3:0]    OP_ADD = 4'b0000;
  localparam logic [3:0]    OP_ADI = 4'b0001;
  localparam logic [3:0]    OP_NDU = 4'b0010;
  localparam logic [3:0]    OP_LHI = 4'b0011;
  localparam logic [3:0]    OP_LW  = 4'b0100;
  localparam logic [3:0]    OP_SW  = 4'b0101;
  localparam logic [RW-1:0] PC_REG = '1;

  // Instruction fields
  logic [3:0]    opcode;
  logic [RW-1:0] ra, rb, rc;
  assign opcode    = id_instr[15:12];
  assign ra        = id_instr[11:9];
  assign rb        = id_instr[8:6];
  assign rc        = id_instr[5:3];
  assign rf_addr_a = ra;
  assign rf_addr_b = rb;

  // Decoded controls
  logic          use_a, use_b, writes, use_imm, is_lhi, a_from_b;
  logic [RW-1:0] dest;
  logic [1:0]    cz;

  // Classify the instruction: sources read, destination, immediate form
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch.
    use_a    = 1'b0;
    use_b    = 1'b0;
    writes   = 1'b0;
    use_imm  = 1'b0;
    is_lhi   = 1'b0;
    a_from_b = 1'b0;
    dest     = '0;
    cz       = 2'b00;
    unique case (opcode)
      OP_ADD, OP_NDU: begin
        use_a  = 1'b1;
        use_b  = 1'b1;
        writes = 1'b1;
        dest   = rc;
        cz     = id_instr[1:0];
      end
      OP_ADI: begin
        use_a   = 1'b1;
        writes  = 1'b1;
        use_imm = 1'b1;
        dest    = rb;
      end
      OP_LHI: begin
        writes = 1'b1;
        is_lhi = 1'b1;
        dest   = ra;
      end
      // LW's base register is rb; it travels in opA beside the offset in opB
      OP_LW: begin
        use_b    = 1'b1;
        writes   = 1'b1;
        use_imm  = 1'b1;
        a_from_b = 1'b1;
        dest     = ra;
      end
      OP_SW: begin
        use_a   = 1'b1;
        use_b   = 1'b1;
        use_imm = 1'b1;
      end
      default: ;
    endcase
  end

  // An EX result that cannot be bypassed: loads always, any writer without forwarding
  logic ex_late;
`ifdef OPERAND_FORWARD_EN
  assign ex_late = ex_wr_valid & ex_is_load;
`else
  assign ex_late = ex_wr_valid;
  logic unused_ex;
  assign unused_ex = ^{ex_wr_data, ex_is_load};
`endif

  // Value of source r, newest producer first; R7 always reads as the PC
  function automatic logic [DW-1:0] src_value(input logic [RW-1:0] r,
                                              input logic [DW-1:0] rf_val);
    if (r == PC_REG) return id_pc;
`ifdef OPERAND_FORWARD_EN
    if (ex_wr_valid && !ex_is_load && r == ex_wr_reg) return ex_wr_data;
`endif
    if (wb_wr_valid && r == wb_wr_reg) return wb_wr_data;
    return rf_val;
  endfunction

  // The held bundle's result does not exist yet, so its dest is busy
  logic          held_writes;
  logic [RW-1:0] held_dest;
  assign held_dest = rr_bundle[2*DW+2 +: RW];

  function automatic logic src_busy(input logic [RW-1:0] r);
    return (r != PC_REG) &&
           ((rr_valid && held_writes && r == held_dest) ||
            (ex_late && r == ex_wr_reg));
  endfunction

  logic hazard, take;
  assign hazard   = (use_a && src_busy(ra)) || (use_b && src_busy(rb));
  assign id_ready = (!rr_valid || ex_ready) && !hazard && !flush;
  assign take     = id_valid && id_ready;

  // Operand assembly
  logic [DW-1:0] val_a, val_b, op_a, op_b;
  assign val_a = src_value(ra, rf_data_a);
  assign val_b = src_value(rb, rf_data_b);
  assign op_a  = is_lhi   ? {id_instr[8:0], 7'b0} :
                 a_from_b ? val_b : val_a;
  assign op_b  = is_lhi   ? '0 :
                 use_imm  ? {{(DW-6){id_instr[5]}}, id_instr[5:0]} : val_b;

  // Pipeline register: flush kills, capture loads, a departure with no refill bubbles
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the async reset clears all state, so nothing survives a mid-stall reset.
    if (!rst_n) begin
      // NOTE: sequential state uses <= so every flop samples pre-edge values.
      rr_valid    <= 1'b0;
      rr_bundle   <= '0;
      held_writes <= 1'b0;
    end else if (flush) begin
      rr_valid <= 1'b0;
    end else if (take) begin
      rr_valid    <= 1'b1;
      rr_bundle   <= {opcode, dest, cz, op_a, op_b};
      held_writes <= writes;
    end else if (ex_ready) begin
      rr_valid <= 1'b0;
    end
  end

  // Saturating count of cycles an offered instruction was held back by a hazard
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (id_valid && hazard && !flush && stall_cnt != '1) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule
